// File: rtl/seg7_scan_if.sv
// seg7_scan_if: segment/anode sample bus and decoded-frame handshake for seg7_scan_decoder
interface seg7_scan_if;
    logic [7:0]  seg;
    logic [7:0]  an;
    logic        out_ready;
    logic        out_valid;
    logic [31:0] value;
    logic [7:0]  digit_err;
    logic        overrun;
    modport master (output seg, an, out_ready, input out_valid, value, digit_err, overrun);
    modport slave  (input seg, an, out_ready, output out_valid, value, digit_err, overrun);
endinterface

// File: rtl/seg7_scan_decoder.sv
// seg7_scan_decoder: recovers an 8-digit hex frame from a sniffed multiplexed 7-segment scan.
// Define SEG7_DP_CHECK_EN to flag digits whose decimal point is lit and include dp in stability checks.
module seg7_scan_decoder #(
    parameter int STABLE_CYCLES = 4
) (
    input logic       clk,
    input logic       reset,
    seg7_scan_if.slave io_scan
);
`ifdef SEG7_DP_CHECK_EN
    localparam logic [15:0] CMP_MASK = 16'hFFFF;
`else
    localparam logic [15:0] CMP_MASK = 16'hFF7F;
`endif
    logic [15:0] r_s1, r_s2, r_prev;
    logic [7:0]  r_cnt, r_mask, r_sh_err, r_err;
    logic [31:0] r_sh_val, r_value;
    logic        r_valid, r_ovr;
    logic [15:0] w_smp;
    logic [7:0]  w_an, w_cnt_nxt, w_mask_nxt, w_sh_err_nxt;
    logic [6:0]  w_seg;
    logic [31:0] w_sh_val_nxt;
    logic [3:0]  w_nib;
    logic [2:0]  w_idx;
    logic        w_one, w_same, w_hit, w_bad, w_dp, w_done;
    assign w_smp  = r_s2 & CMP_MASK;
    assign w_an   = r_s2[15:8];
    assign w_seg  = r_s2[6:0];
    assign w_one  = $onehot(~w_an);
    assign w_same = w_smp == r_prev;
`ifdef SEG7_DP_CHECK_EN
    assign w_dp = ~r_s2[7];
`else
    assign w_dp = 1'b0;
`endif
    assign w_cnt_nxt = (!w_one || !w_same) ? 8'd0 : (&r_cnt ? r_cnt : r_cnt + 8'd1);
    assign w_hit     = w_one && w_same && r_cnt == 8'(STABLE_CYCLES - 2) && !r_mask[w_idx];
    assign w_mask_nxt = r_mask | (8'(w_hit) << w_idx);
    assign w_done     = w_mask_nxt == 8'hFF;
    always_comb begin
        w_idx = '0;
        for (int i = 0; i < 8; i++)
            if (!w_an[i]) w_idx = 3'(i);
    end
    always_comb begin
        w_nib = 4'h0;
        w_bad = 1'b0;
        case (w_seg)
            7'h01: w_nib = 4'h0;
            7'h4F: w_nib = 4'h1;
            7'h12: w_nib = 4'h2;
            7'h06: w_nib = 4'h3;
            7'h4C: w_nib = 4'h4;
            7'h24: w_nib = 4'h5;
            7'h20: w_nib = 4'h6;
            7'h0F: w_nib = 4'h7;
            7'h00: w_nib = 4'h8;
            7'h04: w_nib = 4'h9;
            7'h08: w_nib = 4'hA;
            7'h60: w_nib = 4'hB;
            7'h31: w_nib = 4'hC;
            7'h42: w_nib = 4'hD;
            7'h30: w_nib = 4'hE;
            7'h38: w_nib = 4'hF;
            default: w_bad = 1'b1;
        endcase
    end
    always_comb begin
        w_sh_val_nxt = r_sh_val;
        w_sh_err_nxt = r_sh_err;
        if (w_hit) begin
            w_sh_val_nxt[{w_idx, 2'b00} +: 4] = w_nib;
            w_sh_err_nxt[w_idx]               = w_bad | w_dp;
        end
    end
    // A completed frame is forwarded straight from the shadow-next values so out_valid rises one clock after the last capture.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_s1     <= '0;
            r_s2     <= '0;
            r_prev   <= '0;
            r_cnt    <= '0;
            r_mask   <= '0;
            r_sh_val <= '0;
            r_sh_err <= '0;
            r_value  <= '0;
            r_err    <= '0;
            r_valid  <= 1'b0;
            r_ovr    <= 1'b0;
        end else begin
            r_s1     <= {io_scan.an, io_scan.seg};
            r_s2     <= r_s1;
            r_prev   <= w_smp;
            r_cnt    <= w_cnt_nxt;
            r_sh_val <= w_sh_val_nxt;
            r_sh_err <= w_sh_err_nxt;
            r_mask   <= w_done ? 8'h00 : w_mask_nxt;
            if (w_done && (!r_valid || io_scan.out_ready)) begin
                r_valid <= 1'b1;
                r_value <= w_sh_val_nxt;
                r_err   <= w_sh_err_nxt;
            end else if (w_done) begin
                r_ovr <= 1'b1;
            end else if (r_valid && io_scan.out_ready) begin
                r_valid <= 1'b0;
            end
        end
    end
    assign io_scan.out_valid = r_valid;
    assign io_scan.value     = r_value;
    assign io_scan.digit_err = r_err;
    assign io_scan.overrun   = r_ovr;
endmodule

// File: tb/tb_seg7_scan_decoder.sv
// tb_seg7_scan_decoder: directed scans with hand-computed frames for seg7_scan_decoder (STABLE_CYCLES=4).
module tb_seg7_scan_decoder;
    logic        clk = 1'b0;
    logic        reset;
    logic        dp = 1'b1;
    int          n_run = 0;
    int          n_fail = 0;
    int          vcnt = 0;
    int          v0;
    logic [31:0] last_val = '0;
    logic [7:0]  last_err = '0;
    seg7_scan_if io();
    seg7_scan_decoder #(.STABLE_CYCLES(4)) dut (.clk(clk), .reset(reset), .io_scan(io));
    always #5 clk = ~clk;
    always @(negedge clk) begin
        if (io.out_valid) begin
            vcnt++;
            last_val = io.value;
            last_err = io.digit_err;
        end
    end
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask
    function automatic logic [6:0] enc(input logic [3:0] n);
        case (n)
            4'h0: enc = 7'h01;  4'h1: enc = 7'h4F;  4'h2: enc = 7'h12;  4'h3: enc = 7'h06;
            4'h4: enc = 7'h4C;  4'h5: enc = 7'h24;  4'h6: enc = 7'h20;  4'h7: enc = 7'h0F;
            4'h8: enc = 7'h00;  4'h9: enc = 7'h04;  4'hA: enc = 7'h08;  4'hB: enc = 7'h60;
            4'hC: enc = 7'h31;  4'hD: enc = 7'h42;  4'hE: enc = 7'h30;  default: enc = 7'h38;
        endcase
    endfunction
    task automatic show(input int d, input logic [6:0] c, input int n);
        io.an  = ~(8'b1 << d);
        io.seg = {dp, c};
        repeat (n) @(negedge clk);
    endtask
    task automatic idle(input int n);
        io.an  = 8'hFF;
        io.seg = 8'hFF;
        repeat (n) @(negedge clk);
    endtask
    task automatic scan(input logic [31:0] vals);
        for (int i = 0; i < 8; i++) show(i, enc(vals[4*i +: 4]), 6);
    endtask
    initial begin
        io.an = 8'hFF;
        io.seg = 8'hFF;
        io.out_ready = 1'b1;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_valid", 32'(io.out_valid), 32'd0);
        check("rst_value", io.value, 32'h0);
        check("rst_err", 32'(io.digit_err), 32'h0);
        check("rst_ovr", 32'(io.overrun), 32'd0);
        reset = 1'b0;
        // basic frame, one-cycle out_valid pulse with out_ready high
        v0 = vcnt;
        scan(32'h87654321);
        idle(8);
        check("basic_pulses", 32'(vcnt - v0), 32'd1);
        check("basic_value", last_val, 32'h87654321);
        check("basic_err", 32'(last_err), 32'h00);
        check("basic_valid_low", 32'(io.out_valid), 32'd0);
        check("basic_ovr", 32'(io.overrun), 32'd0);
        // 3-cycle glitch on digit 3 must be ignored
        v0 = vcnt;
        show(0, enc(4'hA), 6); show(1, enc(4'hB), 6); show(2, enc(4'hC), 6);
        show(3, enc(4'hE), 3); show(3, enc(4'h9), 8);
        show(4, enc(4'hD), 6); show(5, enc(4'hE), 6); show(6, enc(4'hF), 6); show(7, enc(4'h0), 6);
        idle(8);
        check("glitch_pulses", 32'(vcnt - v0), 32'd1);
        check("glitch_value", last_val, 32'h0FED9CBA);
        check("glitch_err", 32'(last_err), 32'h00);
        // blank digit 5 and a re-scan of digit 0 before completion
        v0 = vcnt;
        for (int i = 0; i < 5; i++) show(i, enc(4'(i + 1)), 6);
        show(0, enc(4'h9), 6);
        show(5, 7'h7F, 6);
        show(6, enc(4'h7), 6); show(7, enc(4'h8), 6);
        idle(8);
        check("blank_pulses", 32'(vcnt - v0), 32'd1);
        check("blank_value", last_val, 32'h87054321);
        check("blank_err", 32'(last_err), 32'h20);
        // reverse order, then two anodes low must not capture
        v0 = vcnt;
        for (int d = 7; d >= 2; d--) show(d, enc(4'(d)), 6);
        io.an = 8'hFC;
        io.seg = {1'b1, enc(4'hF)};
        repeat (20) @(negedge clk);
        idle(4);
        check("multi_an_nocomplete", 32'(vcnt - v0), 32'd0);
        show(0, enc(4'h0), 6); show(1, enc(4'h1), 6);
        idle(8);
        check("multi_an_pulses", 32'(vcnt - v0), 32'd1);
        check("multi_an_value", last_val, 32'h76543210);
        // back-pressure: second frame dropped, overrun sticky
        io.out_ready = 1'b0;
        scan(32'h13579BDF);
        idle(8);
        check("bp_valid1", 32'(io.out_valid), 32'd1);
        check("bp_value1", io.value, 32'h13579BDF);
        check("bp_ovr1", 32'(io.overrun), 32'd0);
        scan(32'h2468ACE0);
        idle(8);
        check("bp_valid2", 32'(io.out_valid), 32'd1);
        check("bp_value2", io.value, 32'h13579BDF);
        check("bp_ovr2", 32'(io.overrun), 32'd1);
        io.out_ready = 1'b1;
        @(negedge clk);
        check("bp_valid_fall", 32'(io.out_valid), 32'd0);
        check("bp_value_hold", io.value, 32'h13579BDF);
        // reset aborts a partial frame and clears overrun
        for (int i = 0; i < 4; i++) show(i, enc(4'hF), 6);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        check("rst2_ovr", 32'(io.overrun), 32'd0);
        check("rst2_valid", 32'(io.out_valid), 32'd0);
        check("rst2_value", io.value, 32'h0);
        reset = 1'b0;
        idle(2);
        v0 = vcnt;
        dp = 1'b0;
        scan(32'hFEDCBA98);
        idle(8);
        dp = 1'b1;
        check("rst2_pulses", 32'(vcnt - v0), 32'd1);
        check("rst2_frame", last_val, 32'hFEDCBA98);
`ifdef SEG7_DP_CHECK_EN
        check("dp_err", 32'(last_err), 32'hFF);
`else
        check("dp_err", 32'(last_err), 32'h00);
`endif
        check("rst2_ovr_after", 32'(io.overrun), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule

// File: doc/seg7_scan_decoder.md
SEG7_SCAN_DECODER -- requirements
Module: seg7_scan_decoder

Interface
REQ-001 Parameter STABLE_CYCLES, default 4, range 2..255; consecutive identical cycles before a digit sample is accepted.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 seg  input  8  sampled segment bus {dp,a,b,c,d,e,f,g}, active-low (0 = lit).
REQ-005 an  input  8  sampled digit enables, active-low; an[i] low selects digit i.
REQ-006 out_ready  input  1  consumer accepts the current frame.
REQ-007 out_valid  output  1  a complete frame is held on value/digit_err.
REQ-008 value  output  32  decoded frame; digit i occupies bits [4i+3:4i].
REQ-009 digit_err  output  8  per-digit flag: bit i set when digit i held an undecodable pattern.
REQ-010 overrun  output  1  sticky: a completed frame was dropped.

Function
REQ-011 Inputs SHALL pass through two register stages before any use; all timing below counts from the second stage.
REQ-012 A sample SHALL be valid only when exactly one an bit is low; otherwise the stability counter clears and nothing is captured.
REQ-013 The stability counter SHALL increment, saturating, while {an,seg} equals the previous cycle's value, and clear to 0 on any change.
REQ-014 A digit SHALL be captured once, in the cycle the counter reaches STABLE_CYCLES-1, and only if that digit is not already captured in the current frame.
REQ-015 Decode on seg[6:0]: 01->0, 4F->1, 12->2, 06->3, 4C->4, 24->5, 20->6, 0F->7, 00->8, 04->9, 08->A, 60->B, 31->C, 42->D, 30->E, 38->F (hex).
REQ-016 Any other seg[6:0], including blank 7F, SHALL capture nibble 0 and set the digit's shadow error bit.
REQ-017 Captured nibbles and error bits SHALL go to shadow registers, with an 8-bit captured mask recording which digits are present.
REQ-018 When the mask becomes FF, the frame is complete; the mask SHALL clear in the same cycle.
REQ-019 On frame complete with out_valid low, or with out_valid and out_ready both high, value and digit_err SHALL load from shadow and out_valid SHALL be 1 the next cycle.
REQ-020 On frame complete with out_valid high and out_ready low, the frame SHALL be dropped, value held, and overrun set.
REQ-021 out_valid SHALL fall the cycle after out_valid and out_ready are both high, unless REQ-019 reloads in that same cycle.
REQ-022 value and digit_err SHALL be stable while out_valid is high and out_ready is low.
REQ-023 A digit re-scanned before the frame completes SHALL be ignored; a frame's digits may arrive in any order.
REQ-024 Latency from the 8th digit's qualifying cycle to out_valid high SHALL be 1 clock.

Reset
REQ-025 When reset is high at a clock edge, the following SHALL clear to 0: out_valid, value, digit_err, overrun, shadow registers, captured mask, stability counter, and both input register stages.
REQ-026 Reset SHALL abort a partial frame; capture restarts from an empty mask in the first cycle after reset is released.

Configuration
REQ-027 With macro SEG7_DP_CHECK_EN defined, a captured digit with seg[7]=0 (decimal point lit) SHALL set that digit's error bit; its nibble still decodes per REQ-015.
REQ-028 Without SEG7_DP_CHECK_EN, seg[7] SHALL be ignored entirely, including in the stability comparison.

Verification
REQ-029 Scan digits 0..7 with patterns for 1,2,3,4,5,6,7,8, 6 cycles each, out_ready=1 -> value=87654321, digit_err=00, out_valid one cycle.
REQ-030 Digit 3 held 3 cycles, then 8 cycles (STABLE_CYCLES=4) -> captured only on the second dwell; 3-cycle glitch ignored.
REQ-031 Digit 5 shows 7F, the others valid -> nibble 5 = 0, digit_err=20.
REQ-032 an=FC (two low) for 20 cycles -> no capture, mask unchanged.
REQ-033 Two full frames with out_ready=0 -> first frame held, overrun=1; then out_ready=1 -> out_valid falls next cycle.
REQ-034 Reset asserted after 4 digits captured -> next full scan yields only the new frame, and overrun=0.
